ws2812_frame_receiver: RTL and testbench
========================================

// Module: ws2812_frame_receiver
// PURPOSE
//  Decodes a WS2812 single-wire pixel stream (pulse-width coded, 24 bits/pixel, GRB, MSB first)
//  into per-pixel RGB writes for an 8x8 frame store. It is the receiving end of the LED transmit
//  path: it captures frames for loopback checking and drives an external frame/seed memory.
//  It emits one write per pixel and a frame-done pulse on each latch (reset) gap.
// PARAMETERS
//  NUM_PIXELS     64   pixels accepted per frame; later pixels are dropped
//  BIT_THRESH      6   high-pulse length (clk) at or above which the bit decodes as 1
//  MIN_HIGH        2   high pulses shorter than this are glitches -> error
//  MAX_HIGH       14   high pulses longer than this -> error
//  RESET_CYCLES  600   low time (clk) that constitutes a latch gap (50 us at 12 MHz)
// PORTS
//  clk            in   1   system clock (12 MHz nominal)
//  rst_n          in   1   asynchronous active-low reset
//  din            in   1   WS2812 serial data line, asynchronous to clk
//  mem_we         out  1   one-cycle write strobe, one per decoded pixel
//  mem_address    out  6   pixel index, 0..NUM_PIXELS-1, held from mem_we until the next pixel
//  green_data     out  8   first byte received, held with mem_address
//  red_data       out  8   second byte received
//  blue_data      out  8   third byte received
//  frame_done     out  1   one-cycle pulse on latch gap after >=1 bit received
//  frame_pixels   out  7   pixels written in the completed frame, valid with frame_done, held
//  overflow       out  1   one-cycle pulse per complete pixel beyond NUM_PIXELS
//  proto_error    out  1   one-cycle pulse on a timing violation or partial pixel
// BEHAVIOUR
//  - Reset: all outputs 0, counters 0, state SYNC. It is asynchronous, so a mid-pixel assertion
//    discards everything immediately.
//  - din is passed through a 2-flop synchronizer plus 1 history flop. Rise and fall are detected
//    on the synchronized signal. All latencies below are measured from the detected edge.
//  - States (enum):
//    - SYNC: wait for RESET_CYCLES consecutive low cycles; any high restarts the count. Then go to LOW.
//      No bits are decoded in SYNC. This is the state after reset and after any error.
//    - LOW: count low cycles.
//      - A rise goes to HIGH with high_cnt=1.
//      - If low_cnt reaches RESET_CYCLES: latch. If bit_idx!=0 or pixel_cnt!=0, pulse frame_done
//        with frame_pixels=pixel_cnt. If bit_idx!=0 (partial pixel), also pulse proto_error.
//        Clear bit_idx and pixel_cnt and stay in LOW; the latch fires once per gap.
//    - HIGH: count high cycles.
//      - If high_cnt exceeds MAX_HIGH: pulse proto_error, clear bit_idx and pixel_cnt, go to SYNC.
//      - On a fall with high_cnt<MIN_HIGH: pulse proto_error, same clear, go to SYNC.
//      - On any other fall: shift in bit (high_cnt>=BIT_THRESH), bit_idx++, go to LOW with low_cnt=1.
//  - Pixel completion: when bit_idx reaches 24, it wraps to 0.
//    - If pixel_cnt<NUM_PIXELS: on the next cycle assert mem_we, drive mem_address=pixel_cnt and
//      G/R/B from the shift register, and increment pixel_cnt.
//    - Otherwise pulse overflow; no write and no increment.
//    - mem_we is high exactly 1 cycle after the terminating fall is detected.
//  - A latch gap during SYNC produces no frame_done.
//  - Counters saturate and never wrap. low_cnt and high_cnt are $clog2(RESET_CYCLES+1) bits.
//    pixel_cnt is 7 bits and saturates at NUM_PIXELS.
//  - mem_we, frame_done, overflow and proto_error are never high for more than 1 consecutive cycle.
//    frame_done and proto_error may coincide.
// STRUCTURE
//  - ws2812_pkg holds the shared WS2812 constants: the timing defaults (BIT_THRESH, MIN_HIGH,
//    MAX_HIGH, RESET_CYCLES), the bits-per-pixel count 24, and the rx_state_t enum {SYNC, LOW, HIGH}.
//    Transmit-side timing is kept consistent with these values.
//  - Sub-module ws2812_din_sync: a 2-flop synchronizer that outputs din_s, rise and fall.
//  - The top level holds the FSM, counters, shift register and output registers.
// TESTING
//  1. Reset, hold 600 low. Send GRB 10/20/30 with a 15-clk bit period (high 4 = 0, high 9 = 1),
//     then 600 low. Expect one mem_we: address 0, green 0x10, red 0x20, blue 0x30.
//     Then frame_done with frame_pixels=1 and no error.
//  2. Send 65 pixels, pixel i = {i, ~i, i^8'h55}, then a gap. Expect 64 mem_we at addresses 0..63
//     in order with matching data, overflow exactly once, and frame_done with frame_pixels=64.
//  3. Threshold sweep: high 5 -> 0, high 6 -> 1, high 1 -> proto_error plus SYNC,
//     high 15 -> proto_error during the pulse. After an error, no mem_we until a full 600-clk gap.
//  4. Send 10 bits then a 600-clk gap. Expect frame_done (frame_pixels=0) and proto_error together,
//     no mem_we, and the next frame decoding cleanly from address 0.
//  5. Assert rst_n mid-pixel. Expect all outputs 0 immediately. Bits sent after release without
//     a 600-clk gap produce nothing; after the gap a pixel decodes at address 0.

Source files
------------

// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared WS2812 timing defaults, pixel geometry and receiver state encoding
package ws2812_pkg;
  localparam int BIT_THRESH     = 6;
  localparam int MIN_HIGH       = 2;
  localparam int MAX_HIGH       = 14;
  localparam int RESET_CYCLES   = 600;
  localparam int BITS_PER_PIXEL = 24;
  typedef enum logic [1:0] {SYNC, LOW, HIGH} rx_state_t;
endpackage

// File: rtl/ws2812_din_sync.sv
// ws2812_din_sync: two-flop synchronizer for the serial line plus a history flop for edge detection
module ws2812_din_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic din_s_o,
  output logic rise_o,
  output logic fall_o
);
  logic [2:0] sh_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sh_q <= '0;
    else sh_q <= {sh_q[1:0], din_i};
  assign din_s_o = sh_q[1];
  assign rise_o  = sh_q[1] & ~sh_q[2];
  assign fall_o  = ~sh_q[1] & sh_q[2];
endmodule

// File: rtl/ws2812_frame_receiver.sv
// ws2812_frame_receiver: decodes a pulse-width coded GRB stream into per-pixel frame-store writes
module ws2812_frame_receiver #(
  parameter int NUM_PIXELS   = 64,
  parameter int BIT_THRESH   = 6,
  parameter int MIN_HIGH     = 2,
  parameter int MAX_HIGH     = 14,
  parameter int RESET_CYCLES = 600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din_i,
  output logic       mem_we_o,
  output logic [5:0] mem_address_o,
  output logic [7:0] green_data_o,
  output logic [7:0] red_data_o,
  output logic [7:0] blue_data_o,
  output logic       frame_done_o,
  output logic [6:0] frame_pixels_o,
  output logic       overflow_o,
  output logic       proto_error_o
);
  import ws2812_pkg::*;
  localparam int CW = $clog2(RESET_CYCLES + 1);
  logic din_s, rise, fall;
  ws2812_din_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .din_i   (din_i),
    .din_s_o (din_s),
    .rise_o  (rise),
    .fall_o  (fall)
  );
  rx_state_t      state_q;
  logic [CW-1:0]  low_cnt_q, high_cnt_q;
  logic [4:0]     bit_idx_q;
  logic [6:0]     pixel_cnt_q;
  logic [23:0]    shift_q;
  logic           bit_v, low_last;
  logic [23:0]    shift_d;
  assign bit_v    = high_cnt_q >= CW'(BIT_THRESH);
  assign shift_d  = {shift_q[22:0], bit_v};
  assign low_last = low_cnt_q == CW'(RESET_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= SYNC;
      low_cnt_q      <= '0;
      high_cnt_q     <= '0;
      bit_idx_q      <= '0;
      pixel_cnt_q    <= '0;
      shift_q        <= '0;
      mem_we_o       <= 1'b0;
      mem_address_o  <= '0;
      green_data_o   <= '0;
      red_data_o     <= '0;
      blue_data_o    <= '0;
      frame_done_o   <= 1'b0;
      frame_pixels_o <= '0;
      overflow_o     <= 1'b0;
      proto_error_o  <= 1'b0;
    end else begin
      mem_we_o      <= 1'b0;
      frame_done_o  <= 1'b0;
      overflow_o    <= 1'b0;
      proto_error_o <= 1'b0;
      case (state_q)
        SYNC: begin
          if (din_s) low_cnt_q <= '0;
          else if (low_last) begin
            low_cnt_q <= CW'(RESET_CYCLES);
            state_q   <= LOW;
          end else low_cnt_q <= low_cnt_q + 1'b1;
        end
        LOW: begin
          if (rise) begin
            state_q    <= HIGH;
            high_cnt_q <= CW'(1);
          end else if (low_cnt_q != CW'(RESET_CYCLES)) begin
            low_cnt_q <= low_cnt_q + 1'b1;
            // latch gap: fires exactly once because low_cnt_q saturates afterwards
            if (low_last) begin
              if (bit_idx_q != '0 || pixel_cnt_q != '0) begin
                frame_done_o   <= 1'b1;
                frame_pixels_o <= pixel_cnt_q;
              end
              proto_error_o <= bit_idx_q != '0;
              bit_idx_q     <= '0;
              pixel_cnt_q   <= '0;
            end
          end
        end
        HIGH: begin
          if (fall && high_cnt_q >= CW'(MIN_HIGH)) begin
            shift_q   <= shift_d;
            state_q   <= LOW;
            low_cnt_q <= CW'(1);
            if (bit_idx_q == 5'(BITS_PER_PIXEL - 1)) begin
              bit_idx_q <= '0;
              if (pixel_cnt_q < 7'(NUM_PIXELS)) begin
                mem_we_o      <= 1'b1;
                mem_address_o <= pixel_cnt_q[5:0];
                green_data_o  <= shift_d[23:16];
                red_data_o    <= shift_d[15:8];
                blue_data_o   <= shift_d[7:0];
                pixel_cnt_q   <= pixel_cnt_q + 1'b1;
              end else overflow_o <= 1'b1;
            end else bit_idx_q <= bit_idx_q + 1'b1;
          end else if (fall || high_cnt_q >= CW'(MAX_HIGH)) begin
            proto_error_o <= 1'b1;
            bit_idx_q     <= '0;
            pixel_cnt_q   <= '0;
            low_cnt_q     <= '0;
            state_q       <= SYNC;
          end else high_cnt_q <= high_cnt_q + 1'b1;
        end
        default: state_q <= SYNC;
      endcase
    end
  end
endmodule

// File: tb/tb_ws2812_frame_receiver.sv
// tb_ws2812_frame_receiver: randomized WS2812 streams checked by a frame-level model and scoreboard
`timescale 1ns/1ps
module tb_ws2812_frame_receiver;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0;
  logic       mem_we, frame_done, overflow, proto_error;
  logic [5:0] mem_address;
  logic [7:0] green, red, blue;
  logic [6:0] frame_pixels;

  ws2812_frame_receiver dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .din_i          (din),
    .mem_we_o       (mem_we),
    .mem_address_o  (mem_address),
    .green_data_o   (green),
    .red_data_o     (red),
    .blue_data_o    (blue),
    .frame_done_o   (frame_done),
    .frame_pixels_o (frame_pixels),
    .overflow_o     (overflow),
    .proto_error_o  (proto_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // expected responses: {address, G, R, B} writes and {partial, pixels} frame completions
  logic [29:0] wq[$];
  logic [7:0]  fq[$];
  int          exp_err = 0;
  int          exp_ovf = 0;
  bit          synced = 1'b0;
  int          m_pix = 0;
  int          m_bits = 0;

  logic [29:0] we_exp;
  logic [7:0]  fd_exp;
  logic        pw = 1'b0, pf = 1'b0, po = 1'b0, pe = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        chk("we_single", pw, 1'b0);
        chk("write_expected", wq.size() != 0, 1'b1);
        if (wq.size() != 0) begin
          we_exp = wq.pop_front();
          chk("write_addr", mem_address, we_exp[29:24]);
          chk("write_grb", {green, red, blue}, we_exp[23:0]);
        end
      end
      if (frame_done) begin
        chk("fd_single", pf, 1'b0);
        chk("frame_expected", fq.size() != 0, 1'b1);
        if (fq.size() != 0) begin
          fd_exp = fq.pop_front();
          chk("frame_pixels", frame_pixels, fd_exp[6:0]);
          chk("frame_partial_err", proto_error, fd_exp[7]);
        end
      end
      if (proto_error) chk("err_single", pe, 1'b0);
      if (proto_error && !frame_done) begin
        chk("err_expected", exp_err > 0, 1'b1);
        if (exp_err > 0) exp_err--;
      end
      if (overflow) begin
        chk("ovf_single", po, 1'b0);
        chk("ovf_expected", exp_ovf > 0, 1'b1);
        if (exp_ovf > 0) exp_ovf--;
      end
    end
    pw <= mem_we;
    pf <= frame_done;
    po <= overflow;
    pe <= proto_error;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int h, input int l);
    din = 1'b1;
    cyc(h);
    din = 1'b0;
    cyc(l);
  endtask

  // mode 0: 15-clk period with high 4/9; mode 1: random legal widths; mode 2: threshold widths 5/6
  task automatic send_bit(input bit b, input int mode);
    int h, l;
    if (mode == 0) begin
      h = b ? 9 : 4;
      l = 15 - h;
    end else if (mode == 1) begin
      h = b ? $urandom_range(14, 6) : $urandom_range(5, 2);
      l = $urandom_range(8, 2);
    end else begin
      h = b ? 6 : 5;
      l = 9;
    end
    pulse(h, l);
  endtask

  task automatic send_pixel(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b, input int mode);
    logic [23:0] d;
    d = {g, r, b};
    if (synced) begin
      if (m_pix < 64) begin
        wq.push_back({6'(m_pix), d});
        m_pix++;
      end else exp_ovf++;
    end
    for (int i = 23; i >= 0; i--) send_bit(d[i], mode);
  endtask

  task automatic send_rand_pixel();
    send_pixel(8'($urandom), 8'($urandom), 8'($urandom), 1);
  endtask

  task automatic send_bits(input int n);
    if (synced) m_bits += n;
    for (int i = 0; i < n; i++) send_bit(1'($urandom), 1);
  endtask

  task automatic gap();
    if (synced && (m_pix != 0 || m_bits % 24 != 0)) fq.push_back({m_bits % 24 != 0, 7'(m_pix)});
    synced = 1'b1;
    m_pix  = 0;
    m_bits = 0;
    din    = 1'b0;
    cyc(620);
  endtask

  task automatic bad_pulse(input int h);
    if (synced) exp_err++;
    synced = 1'b0;
    m_pix  = 0;
    m_bits = 0;
    pulse(h, 5);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_we"}, mem_we, 1'b0);
    chk({tag, "_addr"}, mem_address, 6'd0);
    chk({tag, "_grb"}, {green, red, blue}, 24'd0);
    chk({tag, "_fd"}, frame_done, 1'b0);
    chk({tag, "_fpix"}, frame_pixels, 7'd0);
    chk({tag, "_ovf"}, overflow, 1'b0);
    chk({tag, "_err"}, proto_error, 1'b0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [7:0] iv;
    cyc(3);
    check_zero("in_reset");
    rst_n = 1'b1;
    cyc(1);
    check_zero("after_reset");
    gap();
    send_pixel(8'h10, 8'h20, 8'h30, 0);
    gap();
    for (int i = 0; i < 65; i++) begin
      iv = 8'(i);
      send_pixel(iv, ~iv, iv ^ 8'h55, 1);
    end
    gap();
    send_pixel(8'hA5, 8'h3C, 8'h0F, 2);
    bad_pulse(1);
    send_rand_pixel();
    gap();
    send_rand_pixel();
    bad_pulse(15);
    send_rand_pixel();
    gap();
    send_rand_pixel();
    gap();
    send_bits(10);
    gap();
    send_rand_pixel();
    gap();
    repeat (4) begin
      n = $urandom_range(4, 1);
      repeat (n) send_rand_pixel();
      gap();
    end
    send_pixel(8'hC3, 8'h7E, 8'h81, 1);
    send_bits(12);
    #2;
    rst_n = 1'b0;
    din = 1'b0;
    synced = 1'b0;
    m_pix = 0;
    m_bits = 0;
    #1;
    check_zero("async_reset");
    cyc(3);
    rst_n = 1'b1;
    send_rand_pixel();
    gap();
    send_rand_pixel();
    gap();
    cyc(50);
    chk("writes_drained", wq.size(), 0);
    chk("frames_drained", fq.size(), 0);
    chk("errors_drained", exp_err, 0);
    chk("overflow_drained", exp_ovf, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
